// File: rtl/selector_stream_n_pkg.sv
// Shared definitions for the N-channel stream selector: mode encoding and
// modulo-N index helper.
package selector_stream_n_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // a + b reduced modulo n; valid for a, b < n and any n (not just powers of 2)
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/selector_stream_n_if.sv
// Producer/consumer handshake bundle for selector_stream_n.
interface selector_stream_n_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned SW = $clog2(N);

  logic                 iMode;
  logic [SW-1:0]        iSel;
  logic [N*WIDTH-1:0]   iData;
  logic [N-1:0]         iValid;
  logic [N-1:0]         oReady;
  logic [WIDTH-1:0]     oData;
  logic [SW-1:0]        oChan;
  logic                 oValid;
  logic                 iReady;

  modport slave (
    input  iMode, iSel, iData, iValid, iReady,
    output oReady, oData, oChan, oValid
  );

  modport master (
    output iMode, iSel, iData, iValid, iReady,
    input  oReady, oData, oChan, oValid
  );
endinterface

// File: rtl/selector_stream_n_rr_arbiter.sv
// Combinational round-robin picker: first valid channel at or after iPtr.
module rr_arbiter_n
  import selector_stream_n_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  iValid,
  input  logic [SW-1:0] iPtr,
  output logic [SW-1:0] oGrant,
  output logic          oGrantValid
);

  int unsigned idx;

  always_comb begin
    oGrant      = '0;
    oGrantValid = 1'b0;
    idx         = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = wrap_add(32'(iPtr), off, N);
      if (!oGrantValid && iValid[idx]) begin
        oGrantValid = 1'b1;
        oGrant      = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/selector_stream_n.sv
// N-channel registered stream selector: fixed-select or round-robin grant
// feeding a single valid/ready output register.
module selector_stream_n
  import selector_stream_n_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  selector_stream_n_if.slave  bus
);

  localparam int unsigned SW = $clog2(N);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic             fix_valid;
  logic [SW-1:0]    rr_grant;
  logic             rr_valid;
  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic [WIDTH-1:0] sel_data;
  logic [N-1:0]     ready;

  rr_arbiter_n #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .iValid      (bus.iValid),
    .iPtr        (ptr_q),
    .oGrant      (rr_grant),
    .oGrantValid (rr_valid)
  );

  // Out-of-range selects must not index iValid, so the range test gates it.
  always_comb begin
    fix_valid = 1'b0;
    if (32'(bus.iSel) < N) fix_valid = bus.iValid[bus.iSel];
  end

  always_comb begin
    load = ~valid_q | bus.iReady;
    if (mode_e'(bus.iMode) == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = bus.iSel;
      grant_valid = fix_valid;
    end
  end

  always_comb begin
    ready    = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == SW'(k)) begin
        sel_data = bus.iData[k*WIDTH +: WIDTH];
        ready[k] = ~iRst & load & grant_valid;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant_valid) begin
        data_d  = sel_data;
        chan_d  = grant;
        valid_d = 1'b1;
        if (mode_e'(bus.iMode) == MODE_RR) ptr_d = SW'(wrap_add(32'(grant), 1, N));
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.oReady = ready;
  assign bus.oData  = data_q;
  assign bus.oChan  = chan_q;
  assign bus.oValid = valid_q;

endmodule
